// File: rtl/wgt_fifo_ctrl.sv
// wgt_fifo_ctrl: sequencer for the weight FIFO array feeding the systolic array.
// It accepts a per-layer configuration, clears the FIFOs, and loads one layer's
// weights under a valid/ready handshake. It then issues one rd_en window per
// pass and rewinds the read pointers between passes.
// Optional feature macro: WGT_CTRL_SKEW_EN. When defined, each rd_en[j] is
// delayed by j cycles to follow the systolic diagonal. When undefined, all
// active lanes read together.
module wgt_fifo_ctrl #(
  parameter int NUM_FIFO          = 16,
  parameter int MAX_WGT_FIFO_SIZE = 4608,
  parameter int LEN_W             = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [4:0]          cfg_num_filter,
  input  logic [LEN_W-1:0]    cfg_wgt_len,
  input  logic [7:0]          cfg_num_pass,
  output logic                cfg_err,
  input  logic                wgt_valid,
  output logic                wgt_ready,
  input  logic                rd_start,
  input  logic                abort,
  output logic                wr_clr,
  output logic                rd_clr,
  output logic                wr_en,
  output logic [4:0]          read_wgt_size,
  output logic [NUM_FIFO-1:0] rd_en,
  output logic                busy,
  output logic                load_done,
  output logic                pass_done,
  output logic                all_done
);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, WAIT_RD, READ} state_e;

  // The skew counter is one bit wider so that len+NUM_FIFO-2 cannot wrap.
  localparam int              TW      = LEN_W + 1;
  localparam logic [4:0]       NF_MAX  = 5'(NUM_FIFO);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_WGT_FIFO_SIZE);

  state_e              state_q, state_d;
  logic [4:0]          nf_q, nf_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [7:0]          np_q, np_d;
  logic [LEN_W-1:0]    wcnt_q, wcnt_d;
  logic [TW-1:0]       t_q, t_d, t_inc, t_end;
  logic [7:0]          pcnt_q, pcnt_d;
  logic [NUM_FIFO-1:0] rd_en_d;
  logic                cfg_err_d, wr_clr_d, rd_clr_d;
  logic                load_done_d, pass_done_d, all_done_d;
  logic                cfg_bad;

  // Read-enable pattern for skew counter value tv.
  function automatic logic [NUM_FIFO-1:0] lane_mask(input logic [TW-1:0] tv,
                                                    input logic [4:0] nf,
                                                    input logic [LEN_W-1:0] len);
    logic [TW-1:0] jv;
    logic [TW-1:0] nfv;
    logic [TW-1:0] lv;
    lane_mask = '0;
    nfv = TW'(nf);
    lv  = {1'b0, len};
    for (int j = 0; j < NUM_FIFO; j++) begin
      jv = TW'(j);
`ifdef WGT_CTRL_SKEW_EN
      lane_mask[j] = (jv < nfv) && (tv >= jv) && (tv < jv + lv);
`else
      lane_mask[j] = (jv < nfv) && (tv < lv);
`endif
    end
  endfunction

  assign cfg_bad = (cfg_num_filter == '0) || (cfg_num_filter > NF_MAX) ||
                   (cfg_wgt_len == '0) || (cfg_wgt_len > LEN_MAX) ||
                   (cfg_num_pass == '0);

  assign t_inc = t_q + TW'(1);
`ifdef WGT_CTRL_SKEW_EN
  assign t_end = {1'b0, len_q} + TW'(nf_q) - TW'(2);
`else
  assign t_end = {1'b0, len_q} - TW'(1);
`endif

  // Handshake and lane gating follow the state directly; abort blocks writes.
  assign cfg_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign wgt_ready     = (state_q == LOAD) && !abort;
  assign wr_en         = wgt_ready && wgt_valid;
  assign read_wgt_size = (state_q == LOAD) ? nf_q : 5'd0;

  // Next-state, counters and registered strobes.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    state_d     = state_q;
    nf_d        = nf_q;
    len_d       = len_q;
    np_d        = np_q;
    wcnt_d      = wcnt_q;
    t_d         = t_q;
    pcnt_d      = pcnt_q;
    rd_en_d     = '0;
    cfg_err_d   = 1'b0;
    wr_clr_d    = 1'b0;
    rd_clr_d    = 1'b0;
    load_done_d = 1'b0;
    pass_done_d = 1'b0;
    all_done_d  = 1'b0;
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      wr_clr_d = 1'b1;
      rd_clr_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (cfg_valid) begin
          nf_d  = cfg_num_filter;
          len_d = cfg_wgt_len;
          np_d  = cfg_num_pass;
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d  = CLR;
            wr_clr_d = 1'b1;
            rd_clr_d = 1'b1;
          end
        end
        CLR: begin
          state_d = LOAD;
          wcnt_d  = '0;
          pcnt_d  = '0;
        end
        LOAD: if (wgt_valid) begin
          wcnt_d = wcnt_q + LEN_W'(1);
          if (wcnt_q == len_q - LEN_W'(1)) begin
            state_d     = WAIT_RD;
            load_done_d = 1'b1;
          end
        end
        WAIT_RD: if (rd_start) begin
          state_d = READ;
          t_d     = '0;
          rd_en_d = lane_mask('0, nf_q, len_q);
        end
        READ: begin
          if (t_q == t_end) begin
            pcnt_d      = pcnt_q + 8'd1;
            pass_done_d = 1'b1;
            rd_clr_d    = 1'b1;
            if (pcnt_q == np_q - 8'd1) begin
              all_done_d = 1'b1;
              state_d    = IDLE;
            end else begin
              state_d = WAIT_RD;
            end
          end else begin
            t_d     = t_inc;
            rd_en_d = lane_mask(t_inc, nf_q, len_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State, configuration, counters and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      state_q   <= IDLE;
      nf_q      <= '0;
      len_q     <= '0;
      np_q      <= '0;
      wcnt_q    <= '0;
      t_q       <= '0;
      pcnt_q    <= '0;
      rd_en     <= '0;
      cfg_err   <= 1'b0;
      wr_clr    <= 1'b0;
      rd_clr    <= 1'b0;
      load_done <= 1'b0;
      pass_done <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      state_q   <= state_d;
      nf_q      <= nf_d;
      len_q     <= len_d;
      np_q      <= np_d;
      wcnt_q    <= wcnt_d;
      t_q       <= t_d;
      pcnt_q    <= pcnt_d;
      rd_en     <= rd_en_d;
      cfg_err   <= cfg_err_d;
      wr_clr    <= wr_clr_d;
      rd_clr    <= rd_clr_d;
      load_done <= load_done_d;
      pass_done <= pass_done_d;
      all_done  <= all_done_d;
    end
  end

endmodule
